// File: rtl/b11_dec_if.sv
// b11_dec_if: symbol handshake and result bus for the b11 descrambler.
// Ports: x_in/stbi (symbol in), x_out/valid/ambig/nomatch/busy (result out).
interface b11_dec_if;
    logic [5:0] x_in;
    logic       stbi;
    logic [5:0] x_out;
    logic       valid;
    logic       ambig;
    logic       nomatch;
    logic       busy;

    modport master (
        output x_in, stbi,
        input  x_out, valid, ambig, nomatch, busy
    );

    modport slave (
        input  x_in, stbi,
        output x_out, valid, ambig, nomatch, busy
    );
endinterface

// File: rtl/b11_dec.sv
// b11_dec: receive-side descrambler. Captures one scrambled 6-bit symbol,
// scans the 28 legal plaintexts (0..26, 63) one per clock through the encoder
// under the current key, reports the first hit and keeps the key in step.
// Ports: clock, reset (async, active-low), bus (b11_dec_if.slave):
//   x_in/stbi in; x_out/valid/ambig/nomatch/busy out.
// Option: B11_DEC_AMBIG_EN scans all candidates and flags multiple hits.
module b11_dec #(
    parameter int KEY_MAX  = 25,
    parameter int KEY_INIT = 0
) (
    input  logic     clock,
    input  logic     reset,
    b11_dec_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [4:0] r_key;
    logic [5:0] r_v;
    logic [4:0] r_idx;
    logic       r_hit;
    logic [5:0] r_first;
    logic [5:0] r_x_out;
    logic       r_valid;
    logic       r_nomatch;
`ifdef B11_DEC_AMBIG_EN
    logic       r_multi;
    logic       r_ambig;
`endif

    logic       w_start;
    logic       w_scan;
    logic       w_done;
    logic [5:0] w_cand;
    logic       w_hit;
    logic       w_last;
    logic       w_roll;

    // Encoder E(r,k); 9-bit wrap arithmetic, wrap loops bounded to 2 steps.
    function automatic logic [5:0] f_enc(input logic [5:0] r,
                                         input logic [4:0] k);
        logic [8:0] m;
        logic [8:0] s;
        logic [5:0] e;
        m = r[0] ? {3'b000, k, 1'b0} : {4'b0000, k};
        if (r[1]) begin
            s = {3'b000, r} + m;
            if (s > 9'd26) s = s - 9'd26;
            if (s > 9'd26) s = s - 9'd26;
        end else begin
            s = {3'b000, r} - m;
            if (s > 9'd63) s = s + 9'd26;
            if (s > 9'd63) s = s + 9'd26;
        end
        case (r[3:2])
            2'd0:    s = s - 9'd21;
            2'd1:    s = s - 9'd42;
            2'd2:    s = s + 9'd7;
            default: s = s + 9'd28;
        endcase
        e = s[8] ? (6'd0 - s[5:0]) : s[5:0];
        if (r == 6'd0 || r == 6'd63)
            e = r;
        return e;
    endfunction

    assign w_last = (r_idx == 5'd27);
    assign w_cand = w_last ? 6'd63 : {1'b0, r_idx};
    assign w_hit  = (f_enc(w_cand, r_key) == r_v);
    assign w_roll = r_hit && (r_first == 6'd0 || r_first == 6'd63);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (!bus.stbi) w_next = S_SCAN;
`ifdef B11_DEC_AMBIG_EN
            S_SCAN: if (w_last) w_next = S_DONE;
`else
            // Stop at the first hit; otherwise run out the list.
            S_SCAN: if (w_hit || w_last) w_next = S_DONE;
`endif
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State decode
    always_comb begin
        w_start = 1'b0;
        w_scan  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:  w_start = !bus.stbi;
            S_SCAN:  w_scan  = 1'b1;
            S_DONE:  w_done  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture, scan bookkeeping, result load, key step
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_key     <= 5'(KEY_INIT);
            r_v       <= '0;
            r_idx     <= '0;
            r_hit     <= 1'b0;
            r_first   <= '0;
            r_x_out   <= '0;
            r_valid   <= 1'b0;
            r_nomatch <= 1'b0;
`ifdef B11_DEC_AMBIG_EN
            r_multi   <= 1'b0;
            r_ambig   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_start) begin
                r_v     <= bus.x_in;
                r_idx   <= '0;
                r_hit   <= 1'b0;
                r_first <= '0;
`ifdef B11_DEC_AMBIG_EN
                r_multi <= 1'b0;
`endif
            end
            if (w_scan) begin
                if (!w_last) r_idx <= r_idx + 5'd1;
                if (w_hit && !r_hit) begin
                    r_hit   <= 1'b1;
                    r_first <= w_cand;
                end
`ifdef B11_DEC_AMBIG_EN
                if (w_hit && r_hit) r_multi <= 1'b1;
`endif
            end
            if (w_done) begin
                r_valid   <= 1'b1;
                r_x_out   <= r_hit ? r_first : 6'd0;
                r_nomatch <= !r_hit;
`ifdef B11_DEC_AMBIG_EN
                r_ambig   <= r_multi;
`endif
                // Only the framing symbols 0 and 63 advance the key.
                if (w_roll)
                    r_key <= (r_key == 5'(KEY_MAX)) ? 5'd0 : r_key + 5'd1;
            end
        end
    end

    assign bus.x_out   = r_x_out;
    assign bus.valid   = r_valid;
    assign bus.nomatch = r_nomatch;
    assign bus.busy    = w_scan | w_done;
`ifdef B11_DEC_AMBIG_EN
    assign bus.ambig   = r_ambig;
`else
    assign bus.ambig   = 1'b0;
`endif

endmodule
